// File: rtl/player_mover.sv
// ---------------------------------------------------------------------------
// player_mover
//
// Moves a solid SPR_W x SPR_H sprite around a frame buffer one pixel per
// accepted request. Move requests are only taken on a slow movement tick
// while the mover is idle. Each candidate target is checked against an
// external obstacle map before the sprite is erased at its old position and
// redrawn at the new one. Reaching the goal position latches did_win and
// parks the mover until reset.
//
// Ports
//   clk         single clock
//   reset       synchronous, active-high
//   move_valid  move request present
//   move_dir    0 none, 1 up, 2 down, 3 left, 4 right, 5-7 none
//   move_ready  request accepted this cycle (idle and on a tick)
//   map_rd      obstacle-map read strobe
//   map_x/y     obstacle-map read address (candidate target)
//   map_black   obstacle bit, valid the cycle after map_rd
//   plot        write vga_color at (vga_x, vga_y)
//   vga_x/y     pixel address
//   vga_color   pixel colour
//   xpos/ypos   current sprite top-left position
//   busy        high in every state except IDLE and WIN
//   did_win     sticky goal flag
// ---------------------------------------------------------------------------
module player_mover #(
    parameter int          X_W         = 8,
    parameter int          Y_W         = 7,
    parameter int          X_MAX       = 159,
    parameter int          Y_MAX       = 119,
    parameter int          SPR_W       = 4,
    parameter int          SPR_H       = 4,
    parameter int          TICK_CYCLES = 524288,
    parameter int          X_INIT      = 0,
    parameter int          Y_INIT      = 0,
    parameter int          WIN_X       = 150,
    parameter int          WIN_Y       = 110,
    parameter logic [2:0]  FG_COLOR    = 3'b100,
    parameter logic [2:0]  BG_COLOR    = 3'b000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           move_valid,
    input  logic [2:0]     move_dir,
    output logic           move_ready,
    output logic           map_rd,
    output logic [X_W-1:0] map_x,
    output logic [Y_W-1:0] map_y,
    input  logic           map_black,
    output logic           plot,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [2:0]     vga_color,
    output logic [X_W-1:0] xpos,
    output logic [Y_W-1:0] ypos,
    output logic           busy,
    output logic           did_win
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int CX_W   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int CY_W   = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [CX_W-1:0]   CX_LAST   = CX_W'(SPR_W - 1);
    localparam logic [CY_W-1:0]   CY_LAST   = CY_W'(SPR_H - 1);

    typedef enum logic [2:0] {
        INIT_DRAW,
        IDLE,
        CHECK,
        CHECK_WAIT,
        ERASE,
        UPDATE,
        DRAW,
        WIN
    } state_t;

    state_t state, next_state;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    logic [CX_W-1:0]   cx;
    logic [CY_W-1:0]   cy;
    logic              scanning;
    logic              scan_last;

    logic [X_W-1:0]    target_x;
    logic [Y_W-1:0]    target_y;
    logic [X_W-1:0]    cand_x;
    logic [Y_W-1:0]    cand_y;
    logic              move_ok;
    logic              accept;
    logic              at_win;

    // -----------------------------------------------------------------------
    // Movement tick: free-running in every state, wraps at TICK_CYCLES-1.
    // -----------------------------------------------------------------------
    assign tick = (tick_cnt == TICK_LAST);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Request handshake. Outputs are forced low while reset is held so the
    // cycle after a reset is sampled never plots, reads or accepts.
    // -----------------------------------------------------------------------
    assign move_ready = (state == IDLE) && tick && !reset;
    assign accept     = move_ready && move_valid;

    // Candidate target: one step on the chosen axis, rejected at the edges
    // instead of wrapping. Unknown directions leave move_ok low.
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        cand_x  = xpos;
        cand_y  = ypos;
        move_ok = 1'b0;
        case (move_dir)
            3'd1: if (ypos != '0) begin
                cand_y  = ypos - Y_W'(1);
                move_ok = 1'b1;
            end
            3'd2: if (ypos < Y_W'(Y_MAX)) begin
                cand_y  = ypos + Y_W'(1);
                move_ok = 1'b1;
            end
            3'd3: if (xpos != '0) begin
                cand_x  = xpos - X_W'(1);
                move_ok = 1'b1;
            end
            3'd4: if (xpos < X_W'(X_MAX)) begin
                cand_x  = xpos + X_W'(1);
                move_ok = 1'b1;
            end
            default: ;
        endcase
    end

    // Target is captured on acceptance so later move_dir changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            target_x <= X_W'(X_INIT);
            target_y <= Y_W'(Y_INIT);
        end else if (accept) begin
            target_x <= cand_x;
            target_y <= cand_y;
        end
    end

    // -----------------------------------------------------------------------
    // Position and goal flag
    // -----------------------------------------------------------------------
    assign at_win = (xpos == X_W'(WIN_X)) && (ypos == Y_W'(WIN_Y));

    always_ff @(posedge clk) begin
        if (reset) begin
            xpos <= X_W'(X_INIT);
            ypos <= Y_W'(Y_INIT);
        end else if (state == UPDATE) begin
            xpos <= target_x;
            ypos <= target_y;
        end
    end

    // Only a completed DRAW counts; the initial draw never sets the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            did_win <= 1'b0;
        end else if ((state == DRAW) && scan_last && at_win) begin
            did_win <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Sprite scan, x fastest. Counters idle at zero outside the draw states
    // so each scan starts at the top-left pixel.
    // -----------------------------------------------------------------------
    assign scanning  = (state == INIT_DRAW) || (state == ERASE) || (state == DRAW);
    assign scan_last = (cx == CX_LAST) && (cy == CY_LAST);

    always_ff @(posedge clk) begin
        if (reset || !scanning) begin
            cx <= '0;
            cy <= '0;
        end else if (cx == CX_LAST) begin
            cx <= '0;
            cy <= scan_last ? '0 : cy + 1'b1;
        end else begin
            cx <= cx + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT_DRAW;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            INIT_DRAW:  if (scan_last) next_state = IDLE;
            // Null and unknown moves are accepted but simply stay in IDLE.
            IDLE:       if (accept && move_ok) next_state = CHECK;
            CHECK:      next_state = CHECK_WAIT;
            CHECK_WAIT: next_state = map_black ? IDLE : ERASE;
            ERASE:      if (scan_last) next_state = UPDATE;
            UPDATE:     next_state = DRAW;
            DRAW:       if (scan_last) next_state = at_win ? WIN : IDLE;
            WIN:        next_state = WIN;
            default:    next_state = INIT_DRAW;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy      = (state != IDLE) && (state != WIN);
    assign map_rd    = (state == CHECK) && !reset;
    assign map_x     = target_x;
    assign map_y     = target_y;

    assign plot      = scanning && !reset;
    assign vga_color = (state == ERASE) ? BG_COLOR : FG_COLOR;
    assign vga_x     = xpos + X_W'(cx);
    assign vga_y     = ypos + Y_W'(cy);

endmodule

// File: tb/tb_player_mover.sv
// ---------------------------------------------------------------------------
// tb_player_mover
//
// Directed bench for player_mover with a 4-cycle tick and a 4x4 sprite.
// The main instance starts at (10,10) with the goal at (11,10); a second
// instance starts at (0,0) to exercise the edge-clamped null moves.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled 3 units after it, so each sample reflects the current cycle.
// ---------------------------------------------------------------------------
module tb_player_mover;

    localparam int         X_W = 8;
    localparam int         Y_W = 7;
    localparam logic [2:0] FG  = 3'b100;
    localparam logic [2:0] BG  = 3'b000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance, start (10,10)
    logic           reset      = 1'b1;
    logic           move_valid = 1'b0;
    logic [2:0]     move_dir   = 3'd0;
    logic           map_black  = 1'b0;
    logic           move_ready, map_rd, plot, busy, did_win;
    logic [X_W-1:0] map_x, vga_x, xpos;
    logic [Y_W-1:0] map_y, vga_y, ypos;
    logic [2:0]     vga_color;

    // corner instance, start (0,0)
    logic           z_reset      = 1'b1;
    logic           z_move_valid = 1'b0;
    logic [2:0]     z_move_dir   = 3'd0;
    logic           z_map_black  = 1'b0;
    logic           z_move_ready, z_map_rd, z_plot, z_busy, z_did_win;
    logic [X_W-1:0] z_map_x, z_vga_x, z_xpos;
    logic [Y_W-1:0] z_map_y, z_vga_y, z_ypos;
    logic [2:0]     z_vga_color;

    player_mover #(
        .TICK_CYCLES(4), .X_INIT(10), .Y_INIT(10), .WIN_X(11), .WIN_Y(10)
    ) dut (
        .clk(clk), .reset(reset),
        .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
        .map_rd(map_rd), .map_x(map_x), .map_y(map_y), .map_black(map_black),
        .plot(plot), .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
        .xpos(xpos), .ypos(ypos), .busy(busy), .did_win(did_win)
    );

    player_mover #(
        .TICK_CYCLES(4), .X_INIT(0), .Y_INIT(0), .WIN_X(11), .WIN_Y(10)
    ) dut_corner (
        .clk(clk), .reset(z_reset),
        .move_valid(z_move_valid), .move_dir(z_move_dir), .move_ready(z_move_ready),
        .map_rd(z_map_rd), .map_x(z_map_x), .map_y(z_map_y), .map_black(z_map_black),
        .plot(z_plot), .vga_x(z_vga_x), .vga_y(z_vga_y), .vga_color(z_vga_color),
        .xpos(z_xpos), .ypos(z_ypos), .busy(z_busy), .did_win(z_did_win)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // drive point of the next cycle
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // sample point of the current cycle
    task automatic smp();
        #2;
    endtask

    // Checks `count` consecutive plot cycles in x-fastest order. With `here`
    // set the caller is already at the drive point of the first scan cycle.
    task automatic check_scan(input string tag, input logic [2:0] color,
                              input int x0, input int y0, input int count, input bit here);
        for (int i = 0; i < count; i++) begin
            if (i != 0 || !here) adv();
            smp();
            check({tag, "_plot"},  plot,      1);
            check({tag, "_color"}, vga_color, color);
            check({tag, "_x"},     vga_x,     x0 + i % 4);
            check({tag, "_y"},     vga_y,     y0 + i / 4);
        end
    endtask

    // Returns at the sample point of the acceptance cycle.
    task automatic wait_ready(input int budget);
        for (int i = 0; i < budget; i++) begin
            adv();
            smp();
            if (move_ready) return;
        end
        check("ready_timeout", move_ready, 1);
    endtask

    task automatic z_wait_ready(input int budget);
        for (int i = 0; i < budget; i++) begin
            adv();
            smp();
            if (z_move_ready) return;
        end
        check("z_ready_timeout", z_move_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] null_dirs [2];
        logic [2:0] edge_dirs [2];
        null_dirs = '{3'd0, 3'd6};
        edge_dirs = '{3'd3, 3'd1};

        // ---------------- reset state ----------------
        repeat (3) adv();
        smp();
        check("rst_plot",    plot,       0);
        check("rst_map_rd",  map_rd,     0);
        check("rst_ready",   move_ready, 0);
        check("rst_did_win", did_win,    0);
        check("rst_xpos",    xpos,       10);
        check("rst_ypos",    ypos,       10);

        // ---------------- initial draw: cycles n=0..15 ----------------
        adv();
        reset = 1'b0;
        check_scan("init", FG, 10, 10, 16, 1'b1);

        // ---------------- blocked move up, move_valid held high ----------------
        // Tick phase: count 0 in n=0, so ticks land on n%4==3 (first idle tick n=19).
        // Each blocked move takes CHECK, CHECK_WAIT, then IDLE before the next tick.
        for (int n = 16; n <= 32; n++) begin
            logic exp_ready, exp_rd, exp_busy;
            adv();
            if (n == 16) begin
                move_valid = 1'b1;
                move_dir   = 3'd1;
                map_black  = 1'b1;
            end
            if (n == 31) move_valid = 1'b0;
            smp();
            exp_ready = (n % 4 == 3);
            exp_rd    = (n >= 20) && (n <= 28) && (n % 4 == 0);
            exp_busy  = (n >= 20) && (n <= 29) && (n % 4 <= 1);
            check("hold_ready",  move_ready, exp_ready);
            check("hold_map_rd", map_rd,     exp_rd);
            check("hold_busy",   busy,       exp_busy);
            check("hold_plot",   plot,       0);
            if (exp_rd) begin
                check("blk_map_x", map_x, 10);
                check("blk_map_y", map_y, 9);
            end
        end
        check("blk_ypos", ypos, 10);
        check("blk_xpos", xpos, 10);

        // ---------------- direction codes that mean "no move" ----------------
        map_black = 1'b0;
        for (int k = 0; k < 2; k++) begin
            move_dir   = null_dirs[k];
            move_valid = 1'b1;
            wait_ready(8);
            adv();
            move_valid = 1'b0;
            smp();
            check("nulldir_busy",   busy,   0);
            check("nulldir_map_rd", map_rd, 0);
            check("nulldir_plot",   plot,   0);
        end

        // ---------------- move right, aborted by reset in 7th ERASE cycle ----------------
        move_dir   = 3'd4;
        move_valid = 1'b1;
        wait_ready(8);
        adv();
        move_valid = 1'b0;
        smp();
        check("ab_map_rd", map_rd, 1);
        check("ab_map_x",  map_x,  11);
        check("ab_map_y",  map_y,  10);
        adv();
        smp();
        check("ab_wait_plot", plot, 0);
        check("ab_wait_busy", busy, 1);
        check_scan("ab_erase", BG, 10, 10, 6, 1'b0);
        adv();
        reset = 1'b1;
        smp();
        adv();
        smp();
        check("ab_plot",    plot,       0);
        check("ab_rd",      map_rd,     0);
        check("ab_ready",   move_ready, 0);
        check("ab_did_win", did_win,    0);
        check("ab_xpos",    xpos,       10);
        adv();
        reset = 1'b0;
        check_scan("reinit", FG, 10, 10, 16, 1'b1);
        adv();
        smp();
        check("reinit_busy", busy, 0);
        check("reinit_xpos", xpos, 10);

        // ---------------- winning move right ----------------
        move_dir   = 3'd4;
        move_valid = 1'b1;
        wait_ready(8);
        adv();
        move_valid = 1'b0;
        smp();
        check("win_map_rd", map_rd, 1);
        check("win_map_x",  map_x,  11);
        check("win_map_y",  map_y,  10);
        check("win_busy",   busy,   1);
        adv();
        smp();
        check("win_cw_plot", plot,   0);
        check("win_cw_rd",   map_rd, 0);
        check_scan("win_erase", BG, 10, 10, 16, 1'b0);
        adv();
        smp();
        check("upd_plot",    plot,    0);
        check("upd_xpos",    xpos,    10);
        check("upd_did_win", did_win, 0);
        check_scan("win_draw", FG, 11, 10, 16, 1'b0);
        check("draw_xpos", xpos, 11);
        adv();
        smp();
        check("win_did_win", did_win, 1);
        check("win_idle",    busy,    0);
        check("win_plot",    plot,    0);
        move_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            adv();
            smp();
            check("win_ready",  move_ready, 0);
            check("win_rd",     map_rd,     0);
            check("win_noplot", plot,       0);
        end
        move_valid = 1'b0;
        check("win_xpos", xpos, 11);
        adv();
        reset = 1'b1;
        adv();
        smp();
        check("rst2_did_win", did_win, 0);
        check("rst2_xpos",    xpos,    10);

        // ---------------- corner instance: edge-clamped null moves ----------------
        adv();
        z_reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            adv();
            smp();
            if (!z_busy) break;
        end
        check("z_init_busy", z_busy, 0);
        for (int k = 0; k < 2; k++) begin
            z_move_dir   = edge_dirs[k];
            z_move_valid = 1'b1;
            z_wait_ready(8);
            adv();
            z_move_valid = 1'b0;
            for (int j = 0; j < 3; j++) begin
                if (j != 0) adv();
                smp();
                check("z_null_busy", z_busy,   0);
                check("z_null_rd",   z_map_rd, 0);
                check("z_null_plot", z_plot,   0);
            end
            check("z_null_xpos", z_xpos, 0);
            check("z_null_ypos", z_ypos, 0);
        end
        // a legal move from the corner still reads the map
        z_move_dir   = 3'd4;
        z_map_black  = 1'b1;
        z_move_valid = 1'b1;
        z_wait_ready(8);
        adv();
        z_move_valid = 1'b0;
        smp();
        check("z_right_rd", z_map_rd, 1);
        check("z_right_x",  z_map_x,  1);
        check("z_right_y",  z_map_y,  0);
        repeat (3) adv();
        smp();
        check("z_right_blk_xpos", z_xpos, 0);
        check("z_right_blk_busy", z_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
